// File: rtl/master_port.sv
// master_port -- initiator-side serial bus port.
//
// Takes one parallel read/write request from a master, arbitrates for the
// bus, then shifts the address (and write data) out LSB-first on 1-bit
// lanes. For reads, the returned byte is shifted in and presented with a
// one-cycle m_done pulse.
//
// Optional build macro: MASTER_PORT_TIMEOUT_EN. When it is defined, a
// wait-state watchdog aborts the transfer after TIMEOUT_CYCLES stalled
// cycles and pulses m_err. When it is undefined, m_err is tied low.
//
// Ports:
//   in_clk, reset_n          clock (rising edge), async active-low reset
//   m_req_valid/m_ready      master request handshake
//   m_write, m_addr, m_wdata request fields, latched on accept
//   m_rdata, m_done, m_err   read result, completion pulse, timeout pulse
//   bus_req, bus_grant       arbiter request / grant
//   ser_out_valid_ready      valid while transmitting, ready while receiving
//   ser_in_valid_ready       target ready while transmitting, valid while receiving
//   out_addr, ser_wdata      serial address / write-data bits
//   ser_rdata                serial read-data bit
module master_port #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              in_clk,
   input  logic              reset_n,
   input  logic              m_req_valid,
   input  logic              m_write,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_ready,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_done,
   output logic              m_err,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic              ser_out_valid_ready,
   input  logic              ser_in_valid_ready,
   output logic              out_addr,
   output logic              ser_wdata,
   input  logic              ser_rdata
);

   localparam int CNT_W = $clog2(ADDR_W) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] P1_LAST   = CNT_W'(ADDR_W - DATA_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_ADDR_P1, S_ADDR_P2, S_ADDR_DATA,
      S_RD_WAIT, S_RD_DATA, S_WR_WAIT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_W-1:0] data_sh_q, data_sh_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_q, wr_d;
   logic              low_seen_q, low_seen_d;
   logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
   logic              beat;

   assign m_ready             = (state_q == S_IDLE);
   assign m_done              = (state_q == S_DONE);
   assign bus_req             = (state_q != S_IDLE) && (state_q != S_DONE);
   assign ser_out_valid_ready = (state_q == S_ADDR_P1) || (state_q == S_ADDR_P2) ||
                                (state_q == S_ADDR_DATA) || (state_q == S_RD_DATA);
   assign out_addr            = addr_sh_q[0];
   assign ser_wdata           = data_sh_q[0];
   assign m_rdata             = m_rdata_q;
   assign beat                = ser_out_valid_ready && ser_in_valid_ready && bus_grant;

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             m_err_q, m_err_d;
   assign m_err = m_err_q;
`else
   // Parameter is kept so instantiations stay identical across builds.
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES > 0);
   assign m_err      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_sh_d  = addr_sh_q;
      data_sh_d  = data_sh_q;
      count_d    = count_q;
      wr_d       = wr_q;
      low_seen_d = low_seen_q;
      m_rdata_d  = m_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (m_req_valid) begin
               addr_sh_d = m_addr;
               // Reads keep the data lane at 0 during the address phase.
               data_sh_d = m_write ? m_wdata : '0;
               wr_d      = m_write;
               count_d   = '0;
               state_d   = S_ARB;
            end
         end
         S_ARB: begin
            if (bus_grant) state_d = S_ADDR_P1;
         end
         S_ADDR_P1: begin
            if (beat) begin
               addr_sh_d = addr_sh_q >> 1;
               count_d   = count_q + CNT_ONE;
               if (count_q == P1_LAST) state_d = wr_q ? S_ADDR_DATA : S_ADDR_P2;
            end
         end
         S_ADDR_P2: begin
            if (beat) begin
               addr_sh_d = addr_sh_q >> 1;
               count_d   = count_q + CNT_ONE;
               if (count_q == ADDR_LAST) state_d = S_RD_WAIT;
            end
         end
         S_ADDR_DATA: begin
            if (beat) begin
               addr_sh_d = addr_sh_q >> 1;
               data_sh_d = data_sh_q >> 1;
               count_d   = count_q + CNT_ONE;
               if (count_q == ADDR_LAST) begin
                  state_d    = S_WR_WAIT;
                  low_seen_d = 1'b0;
               end
            end
         end
         S_RD_WAIT: begin
            if (!ser_in_valid_ready) begin
               state_d = S_RD_DATA;
               count_d = '0;
            end
         end
         S_RD_DATA: begin
            if (beat) begin
               data_sh_d = {ser_rdata, data_sh_q[DATA_W-1:1]};
               count_d   = count_q + CNT_ONE;
               if (count_q == DATA_LAST) begin
                  m_rdata_d = {ser_rdata, data_sh_q[DATA_W-1:1]};
                  data_sh_d = '0;
                  state_d   = S_DONE;
               end
            end
         end
         S_WR_WAIT: begin
            // Completion is a low (busy) followed by a high (done).
            if (!ser_in_valid_ready) low_seen_d = 1'b1;
            else if (low_seen_q)     state_d    = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef MASTER_PORT_TIMEOUT_EN
      tmo_d   = '0;
      m_err_d = 1'b0;
      // Counts only while stuck in the same state without progress.
      if (((state_q == S_ARB) || (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT) ||
           (ser_out_valid_ready && !beat)) && (state_d == state_q)) begin
         if (tmo_q == TMO_LAST) begin
            state_d   = S_IDLE;
            m_err_d   = 1'b1;
            addr_sh_d = '0;
            data_sh_d = '0;
            count_d   = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_sh_q  <= '0;
         data_sh_q  <= '0;
         count_q    <= '0;
         wr_q       <= 1'b0;
         low_seen_q <= 1'b0;
         m_rdata_q  <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
         tmo_q      <= '0;
         m_err_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_sh_q  <= addr_sh_d;
         data_sh_q  <= data_sh_d;
         count_q    <= count_d;
         wr_q       <= wr_d;
         low_seen_q <= low_seen_d;
         m_rdata_q  <= m_rdata_d;
`ifdef MASTER_PORT_TIMEOUT_EN
         tmo_q      <= tmo_d;
         m_err_q    <= m_err_d;
`endif
      end
   end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Initiator-side serial bus port, directly upstream of the slave port stage in the system bus.
- Accepts one parallel read or write request from a master.
- Arbitrates for the bus, then serialises the request LSB-first onto the interconnect's 1-bit address/data lanes.
- For reads, deserialises the returned byte and presents it to the master with a done pulse.

Parameters:
ADDR_W, 12, address width in bits
DATA_W, 8, data width in bits; ADDR_W > DATA_W
TIMEOUT_CYCLES, 255, wait-state limit (used only with the optional feature)

Ports:
in_clk  in  1  bus clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
m_req_valid  in  1  master request strobe
m_write  in  1  1=write, 0=read
m_addr  in  ADDR_W  target address
m_wdata  in  DATA_W  write data
m_ready  out  1  port idle, request accepted when m_req_valid&&m_ready
m_rdata  out  DATA_W  read data, valid when m_done
m_done  out  1  one-cycle completion pulse
m_err  out  1  one-cycle timeout pulse (optional feature only; else tied 0)
bus_req  out  1  request to arbiter
bus_grant  in  1  arbiter grant
ser_out_valid_ready  out  1  valid while transmitting, ready while receiving
ser_in_valid_ready  in  1  ready from target while transmitting, valid while receiving
out_addr  out  1  serial address bit
ser_wdata  out  1  serial write-data bit
ser_rdata  in  1  serial read-data bit

Behaviour:
- Reset values: m_ready=1; m_done, m_err, bus_req, ser_out_valid_ready, out_addr and ser_wdata=0; m_rdata=0. Reset mid-transaction aborts immediately to IDLE with no done pulse.
- Registers: addr_sh[ADDR_W], data_sh[DATA_W], count (clog2(ADDR_W)+1 bits), wr flag.
- Serial beat: occurs on a cycle with ser_out_valid_ready=1 && ser_in_valid_ready=1 && bus_grant=1.
  - On a transmit beat, shift addr_sh/data_sh right and increment count.
  - out_addr=addr_sh[0] and ser_wdata=data_sh[0] combinationally.
- Grant: if bus_grant drops mid-transfer, no beat occurs and state and shifters freeze; bus_req stays high.
- States:
  - IDLE: m_ready=1. On accept, latch addr/wdata/write, count=0, bus_req=1, go to ARB. m_ready=0 in every other state.
  - ARB: wait for bus_grant=1, then go to ADDR_P1.
  - ADDR_P1: ser_out_valid_ready=1; send ADDR_W-DATA_W address bits. After the last beat, go to ADDR_DATA if wr, else ADDR_P2.
  - ADDR_P2 (read): send the remaining DATA_W address bits. After the last beat (count==ADDR_W), drop ser_out_valid_ready and go to RD_WAIT.
  - ADDR_DATA (write): each beat carries one address bit and one data bit, DATA_W beats. Then go to WR_WAIT with ser_out_valid_ready=0.
  - RD_WAIT: wait for ser_in_valid_ready=0 (target busy), then go to RD_DATA with count=0.
  - RD_DATA: ser_out_valid_ready=1 (ready). Each cycle ser_in_valid_ready=1, shift ser_rdata into data_sh MSB and increment count. After the DATA_W-th bit, m_rdata=assembled byte, go to DONE.
  - WR_WAIT: wait for ser_in_valid_ready low, then high (target write complete), then go to DONE.
  - DONE: m_done=1 for exactly one cycle, bus_req=0, go to IDLE.
- Latency, zero wait states:
  - Write: 1 (ARB) + ADDR_W beats + WR_WAIT + 1.
  - Read: 1 + ADDR_W + RD_WAIT + DATA_W + 1.
- A new request is accepted in the cycle after DONE (IDLE), never back-to-back in DONE.
- m_req_valid while m_ready=0 is ignored; no queuing.

Optional Feature:
- Macro MASTER_PORT_TIMEOUT_EN.
- Defined:
  - A counter runs in ARB, RD_WAIT and WR_WAIT, and during stalled beats.
  - It reloads on any state change or beat.
  - On reaching TIMEOUT_CYCLES: pulse m_err for 1 cycle, drop bus_req and ser_out_valid_ready, return to IDLE without m_done. m_rdata is unchanged.
- Undefined: no counter; m_err is constant 0; the port waits indefinitely.

Test Plan:
- Write addr=0xA5C, data=0x3E, grant and ready always high:
  - out_addr LSB-first is 0,0,1,1,1,0,1,0,0,1,0,1.
  - ser_wdata is 0,1,1,1,1,1,0,0 during beats 5-12.
  - After target low→high in WR_WAIT, m_done pulses once.
- Read addr=0x123:
  - 12 address beats, ser_wdata=0.
  - Target drops valid 2 cycles, then sends 1,0,1,0,0,1,0,1.
  - Result: m_rdata=0xA5 with m_done.
- Grant withheld 5 cycles in ARB, then dropped for 3 cycles mid-address:
  - No beats while grant low.
  - Address bits are sent unchanged, and the total sequence is correct.
- ser_in_valid_ready toggling 1/0 every cycle during a read:
  - Exactly DATA_W data bits are captured, and m_rdata is correct.
- reset_n asserted during ADDR_DATA:
  - All outputs at reset values asynchronously; m_ready=1.
  - No m_done.
  - The next request completes normally.
- With MASTER_PORT_TIMEOUT_EN and TIMEOUT_CYCLES=10, target never drops ready in WR_WAIT:
  - m_err pulses exactly once, bus_req=0, port returns to IDLE.
